handshake_constant_rep: RTL and testbench

Parametrised elastic constant source for the dataflow handshake fabric. Each token accepted on the control channel produces REPEAT output tokens carrying a constant. A two-entry token buffer breaks every combinational valid/ready path between the channels, so the block can sit on timing-critical edges where a purely combinational constant cannot. An optional runtime override lets the host retarget the constant without resynthesis.

---
 rtl/handshake_pkg.sv | 26 ++
 rtl/handshake_token_fifo2.sv | 90 +++++++++
 rtl/handshake_constant_rep.sv | 106 ++++++++++
 tb/tb_handshake_constant_rep.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// ============================================================================
//  Module      : handshake_pkg
//  Description : Shared types and helpers for the elastic handshake units:
//                occupancy type of a two-entry token buffer and the width
//                helper for repeat counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package handshake_pkg;

    // Occupancy of a two-entry buffer: 0, 1 or 2 tokens.
    typedef logic [1:0] occ_t;

    localparam occ_t c_occ_empty = 2'd0;
    localparam occ_t c_occ_full  = 2'd2;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int rep_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_token_fifo2.sv
// ============================================================================
//  Module      : handshake_token_fifo2
//  Description : Two-entry token FIFO with registered not-full / not-empty
//                flags, so neither handshake side sees a combinational path
//                from the other. PAYLOAD_W may be 0 for pure-token use; then
//                no payload storage exists and o_pop_data is a constant.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module handshake_token_fifo2
    import handshake_pkg::*;
#(
    parameter int                 PAYLOAD_W     = 0,
    parameter int                 STORE_W       = (PAYLOAD_W > 0) ? PAYLOAD_W : 1,
    parameter logic [STORE_W-1:0] RESET_PAYLOAD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  logic [STORE_W-1:0] i_push_data,
    output logic               o_pop_valid,
    input  logic               i_pop,
    output logic [STORE_W-1:0] o_pop_data
);

    logic r_wr_ptr;
    logic r_rd_ptr;
    occ_t r_cnt;
    logic r_not_full;
    logic r_not_empty;

    logic w_push;
    logic w_pop;
    occ_t w_cnt_next;

    // Handshake qualification and next occupancy.
    always_comb begin
        w_push     = i_push_valid && r_not_full;
        w_pop      = i_pop && r_not_empty;
        w_cnt_next = r_cnt + occ_t'(w_push) - occ_t'(w_pop);
    end

    // Pointers, occupancy and the registered flags (derived from next count).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= c_occ_empty;
            r_not_full  <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_cnt       <= w_cnt_next;
            r_not_full  <= (w_cnt_next < c_occ_full);
            r_not_empty <= (w_cnt_next != c_occ_empty);
        end
    end

    assign o_push_ready = r_not_full;
    assign o_pop_valid  = r_not_empty;

    generate
        if (PAYLOAD_W > 0) begin : g_payload
            logic [STORE_W-1:0] r_mem [0:1];

            // Payload captured into the write slot at push time.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[0] <= RESET_PAYLOAD;
                    r_mem[1] <= RESET_PAYLOAD;
                end else if (w_push) begin
                    r_mem[r_wr_ptr] <= i_push_data;
                end
            end

            assign o_pop_data = r_mem[r_rd_ptr];
        end else begin : g_no_payload
            logic w_unused_push_data;
            assign w_unused_push_data = ^i_push_data;
            assign o_pop_data         = RESET_PAYLOAD;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/handshake_constant_rep.sv
// ============================================================================
//  Module      : handshake_constant_rep
//  Description : Elastic constant source. Each accepted control token yields
//                REPEAT output tokens carrying a constant; a two-entry token
//                buffer decouples the control and output handshakes.
//                Optional macro HANDSHAKE_CONST_OVERRIDE_EN adds cfg_we /
//                cfg_data to retarget the constant at runtime; each buffered
//                token then carries the constant captured at push time.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module handshake_constant_rep
    import handshake_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VALUE      = '0,
    parameter int                    REPEAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef HANDSHAKE_CONST_OVERRIDE_EN
    input  logic                  cfg_we,
    input  logic [DATA_WIDTH-1:0] cfg_data,
`endif
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int               c_rep_w    = rep_w(REPEAT);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               w_fire;
    logic               w_rep_done;
    logic               w_pop;

    // A token leaves the buffer only on its final copy.
    always_comb begin
        w_fire     = outs_valid && outs_ready;
        w_rep_done = (r_rep_cnt == c_rep_last);
        w_pop      = w_fire && w_rep_done;
    end

    // Copy counter for the head token; restarts whenever the head is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (w_fire) begin
            if (w_rep_done) r_rep_cnt <= '0;
            else            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign outs_last = outs_valid && w_rep_done;

`ifdef HANDSHAKE_CONST_OVERRIDE_EN
    logic [DATA_WIDTH-1:0] r_const;

    // Runtime-overridable constant; a same-cycle push still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_const <= VALUE;
        else if (cfg_we) r_const <= cfg_data;
    end

    handshake_token_fifo2 #(
        .PAYLOAD_W     (DATA_WIDTH),
        .STORE_W       (DATA_WIDTH),
        .RESET_PAYLOAD (VALUE)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (ctrl_valid),
        .o_push_ready (ctrl_ready),
        .i_push_data  (r_const),
        .o_pop_valid  (outs_valid),
        .i_pop        (w_pop),
        .o_pop_data   (outs)
    );
`else
    logic w_unused_head;

    handshake_token_fifo2 #(
        .PAYLOAD_W (0)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (ctrl_valid),
        .o_push_ready (ctrl_ready),
        .i_push_data  (1'b0),
        .o_pop_valid  (outs_valid),
        .i_pop        (w_pop),
        .o_pop_data   (w_unused_head)
    );

    assign outs = VALUE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_handshake_constant_rep.sv
// ============================================================================
//  Module      : tb_handshake_constant_rep
//  Description : Directed bench for handshake_constant_rep with REPEAT=1,
//                REPEAT=3 and REPEAT=5 instances sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_handshake_constant_rep;

    localparam logic [31:0] c_val  = 32'h0000_1234;
    localparam logic [31:0] c_beef = 32'h0000_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        cfg_we   = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_off  = 1'b0;

    logic        cv1, cr1, ov1, or1, ol1;
    logic [31:0] o1;
    logic        cv3, cr3, ov3, or3, ol3;
    logic [31:0] o3;
    logic        cv5, cr5, ov5, or5, ol5;
    logic [31:0] o5;

    handshake_constant_rep #(.DATA_WIDTH(32), .VALUE(c_val), .REPEAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef HANDSHAKE_CONST_OVERRIDE_EN
        .cfg_we(cfg_we), .cfg_data(cfg_data),
`endif
        .ctrl_valid(cv1), .ctrl_ready(cr1), .outs(o1),
        .outs_valid(ov1), .outs_ready(or1), .outs_last(ol1));

    handshake_constant_rep #(.DATA_WIDTH(32), .VALUE(c_val), .REPEAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
`ifdef HANDSHAKE_CONST_OVERRIDE_EN
        .cfg_we(cfg_off), .cfg_data(cfg_data),
`endif
        .ctrl_valid(cv3), .ctrl_ready(cr3), .outs(o3),
        .outs_valid(ov3), .outs_ready(or3), .outs_last(ol3));

    handshake_constant_rep #(.DATA_WIDTH(32), .VALUE(c_val), .REPEAT(5)) u_dut5 (
        .clk(clk), .rst(rst),
`ifdef HANDSHAKE_CONST_OVERRIDE_EN
        .cfg_we(cfg_off), .cfg_data(cfg_data),
`endif
        .ctrl_valid(cv5), .ctrl_ready(cr5), .outs(o5),
        .outs_valid(ov5), .outs_ready(or5), .outs_last(ol5));

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int          acc, fires, lasts, fires_at_third, vcount, nout;
    logic        ovf, last_wo_valid;
    logic [31:0] seq [0:2];

    initial begin
        cv1 = 0; or1 = 0; cv3 = 0; or3 = 0; cv5 = 0; or5 = 0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_ready1", cr1, 1'b0);
        chk("rst_valid1", ov1, 1'b0);
        chk("rst_last1",  ol1, 1'b0);
        chk("rst_outs1",  o1,  c_val);
        chk("rst_ready3", cr3, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", cr1, 1'b1);

        // ---------------- REPEAT=1 streaming ----------------
        cv1 = 1; or1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("r1_valid%0d", i), ov1, 1'b1);
            chk($sformatf("r1_last%0d", i),  ol1, 1'b1);
            chk($sformatf("r1_outs%0d", i),  o1,  c_val);
            chk($sformatf("r1_ready%0d", i), cr1, 1'b1);
        end
        cv1 = 0;
        @(negedge clk);
        chk("r1_drained", ov1, 1'b0);

        // ---------------- REPEAT=3 single token ----------------
        cv3 = 1; or3 = 1;
        @(negedge clk);
        cv3 = 0;
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("r3_valid%0d", k), ov3, (k < 3));
            chk($sformatf("r3_last%0d", k),  ol3, (k == 2));
            if (ov3 && or3) fires++;
            @(negedge clk);
        end
        chk("r3_fire_count", fires, 3);

        // ---------------- backpressure, REPEAT=1 ----------------
        or1 = 0; cv1 = 1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (cv1 && cr1) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 2);
        chk("bp_ready_low", cr1, 1'b0);
        chk("bp_valid_held", ov1, 1'b1);
        or1 = 1; fires = 0; fires_at_third = -1;
        for (int i = 0; i < 20; i++) begin
            if (cv1 && cr1) begin
                acc++;
                if (acc == 3) fires_at_third = fires;
            end
            if (ov1 && or1) fires++;
            @(negedge clk);
            cv1 = (acc < 4);
        end
        chk("bp_total_accepted", acc, 4);
        chk("bp_total_fires", fires, 4);
        chk("bp_drain_before_accept", (fires_at_third >= 1), 1'b1);
        chk("bp_empty", ov1, 1'b0);

        // ---------------- reset mid-burst, REPEAT=3 ----------------
        or3 = 0; cv3 = 1;
        @(negedge clk);
        @(negedge clk);
        cv3 = 0; or3 = 1;
        chk("mid_full_ready", cr3, 1'b0);
        @(negedge clk);
        chk("mid_second_copy", {ov3, ol3}, 2'b10);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ov3, 1'b0);
        chk("mid_rst_last",  ol3, 1'b0);
        chk("mid_rst_ready", cr3, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov3) vcount++;
        end
        chk("mid_no_resume", vcount, 0);
        cv3 = 1;
        @(negedge clk);
        cv3 = 0; fires = 0;
        for (int i = 0; i < 6; i++) begin
            if (ov3 && or3) fires++;
            @(negedge clk);
        end
        chk("mid_new_token_fires", fires, 3);

        // ---------------- constant override, REPEAT=1 ----------------
        or1 = 1; nout = 0;
        for (int c = 0; c < 8; c++) begin
            cv1      = (c < 3);
            cfg_we   = (c == 1);
            cfg_data = c_beef;
            if (ov1 && or1 && nout < 3) begin
                seq[nout] = o1;
                nout++;
            end
            @(negedge clk);
        end
        cfg_we = 0;
        chk("ovr_count", nout, 3);
        chk("ovr_tok_a", seq[0], c_val);
        chk("ovr_tok_b", seq[1], c_val);
`ifdef HANDSHAKE_CONST_OVERRIDE_EN
        chk("ovr_tok_c", seq[2], c_beef);
`else
        chk("ovr_tok_c", seq[2], c_val);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cv1 = 1;
        @(negedge clk);
        cv1 = 0;
        chk("ovr_after_rst_valid", ov1, 1'b1);
        chk("ovr_after_rst_outs",  o1,  c_val);
        @(negedge clk);

        // ---------------- random stress, REPEAT=5 ----------------
        acc = 0; fires = 0; lasts = 0; ovf = 0; last_wo_valid = 0;
        for (int i = 0; i < 10000; i++) begin
            cv5 = ($urandom_range(0, 1) == 1);
            or5 = ($urandom_range(0, 3) != 0);
            if (cv5 && cr5) acc++;
            if (ol5 && !ov5) last_wo_valid = 1;
            if (ov5 && or5) begin
                fires++;
                if (ol5) lasts++;
            end
            if (acc - lasts > 2) ovf = 1;
            @(negedge clk);
        end
        cv5 = 0; or5 = 1;
        for (int i = 0; i < 30; i++) begin
            if (ov5 && or5) begin
                fires++;
                if (ol5) lasts++;
            end
            @(negedge clk);
        end
        chk("stress_some_accepted", (acc > 0), 1'b1);
        chk("stress_fires", fires, 5 * acc);
        chk("stress_lasts", lasts, acc);
        chk("stress_no_overflow", ovf, 1'b0);
        chk("stress_last_implies_valid", last_wo_valid, 1'b0);
        chk("stress_drained", ov5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
